// File: rtl/instr_loader_if.sv
// rtl/instr_loader_if.sv - instruction memory write port bundle
//
// Carries one write beat from the loader to the instruction memory.
//   wr_en    one-cycle write strobe
//   wr_addr  word address (ADDR_W bits)
//   wr_data  instruction word (DATA_W bits)
// Modports: master = loader (drives), slave = memory (receives).

interface instr_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 6
) ();

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    input wr_en,
    input wr_addr,
    input wr_data
  );

endinterface

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - pin-driven writer for the CPU instruction store
//
// Accepts instruction words from off-chip pins via a slow strobe handshake
// and writes them sequentially into instruction memory from address 0,
// holding the CPU in reset for the duration of a loading session.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   load_en    async pin level, high = loading session active
//   strobe     async pin, rising edge presents one word
//   data_in    instruction word, held stable by host while strobe is high
//   wr         instruction memory write port (wr_en / wr_addr / wr_data)
//   cpu_rst_n  active-low reset to the CPU core
//   done       one-cycle pulse at the end of a session
//   overflow   sticky: more than DEPTH words offered in this session
//   length     words written in the last completed session

module instr_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 6,
  parameter int DEPTH  = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_en,
  input  logic                strobe,
  input  logic [DATA_W-1:0]   data_in,
  instr_loader_if.master      wr,
  output logic                cpu_rst_n,
  output logic                done,
  output logic                overflow,
  output logic [ADDR_W:0]     length
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Two synchronizer flops per async pin, plus a history flop for edge
  // detection on the synchronized level.
  logic load_s1, load_s2, load_h;
  logic strobe_s1, strobe_s2, strobe_h;

  logic load_rise, load_fall, strobe_edge;

  logic [ADDR_W:0]   cnt, cnt_nxt;
  logic              wr_en_q, wr_en_nxt;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_nxt;
  logic [DATA_W-1:0] wr_data_q, wr_data_nxt;
  logic              cpu_rst_n_q, cpu_rst_n_nxt;
  logic              done_q, done_nxt;
  logic              overflow_q, overflow_nxt;
  logic [ADDR_W:0]   length_q, length_nxt;

  assign load_rise   =  load_s2 & ~load_h;
  assign load_fall   = ~load_s2 &  load_h;
  assign strobe_edge =  strobe_s2 & ~strobe_h;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_s1     <= 1'b0;
      load_s2     <= 1'b0;
      load_h      <= 1'b0;
      strobe_s1   <= 1'b0;
      strobe_s2   <= 1'b0;
      strobe_h    <= 1'b0;
    end else begin
      load_s1     <= load_en;
      load_s2     <= load_s1;
      load_h      <= load_s2;
      strobe_s1   <= strobe;
      strobe_s2   <= strobe_s1;
      strobe_h    <= strobe_s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cpu_rst_n_q <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      length_q    <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      wr_en_q     <= wr_en_nxt;
      wr_addr_q   <= wr_addr_nxt;
      wr_data_q   <= wr_data_nxt;
      cpu_rst_n_q <= cpu_rst_n_nxt;
      done_q      <= done_nxt;
      overflow_q  <= overflow_nxt;
      length_q    <= length_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    wr_en_nxt     = 1'b0;
    wr_addr_nxt   = wr_addr_q;
    wr_data_nxt   = wr_data_q;
    cpu_rst_n_nxt = cpu_rst_n_q;
    done_nxt      = 1'b0;
    overflow_nxt  = overflow_q;
    length_nxt    = length_q;

    case (state)
      IDLE: begin
        // CPU runs whenever no session is in progress; strobes are ignored.
        cpu_rst_n_nxt = 1'b1;
        if (load_rise) begin
          cnt_nxt       = '0;
          overflow_nxt  = 1'b0;
          cpu_rst_n_nxt = 1'b0;
          state_nxt     = LOAD;
        end
      end

      LOAD: begin
        cpu_rst_n_nxt = 1'b0;
        if (strobe_edge) begin
          if (cnt < DEPTH_C) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = cnt[ADDR_W-1:0];
            wr_data_nxt = data_in;
            cnt_nxt     = cnt + ONE_C;
          end else begin
            overflow_nxt = 1'b1;
          end
        end
        // A strobe coinciding with the end of the session still lands, so
        // the reported length uses the post-write count.
        if (load_fall) begin
          done_nxt   = 1'b1;
          length_nxt = cnt_nxt;
          state_nxt  = FINISH;
        end
      end

      FINISH: begin
        cpu_rst_n_nxt = 1'b1;
        state_nxt     = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign wr.wr_en    = wr_en_q;
  assign wr.wr_addr  = wr_addr_q;
  assign wr.wr_data  = wr_data_q;
  assign cpu_rst_n   = cpu_rst_n_q;
  assign done        = done_q;
  assign overflow    = overflow_q;
  assign length      = length_q;

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - directed self-checking bench for instr_loader

module tb_instr_loader;

  logic       clk;
  logic       rst_n;
  logic       load_en;
  logic       strobe;
  logic [5:0] data_in;

  logic       cpu_rst_n, done, overflow;
  logic [8:0] length;
  logic       cpu_rst_n4, done4, overflow4;
  logic [8:0] length4;

  int tests;
  int fails;
  int cyc;

  instr_loader_if #(.ADDR_W(8), .DATA_W(6)) wr_if ();
  instr_loader_if #(.ADDR_W(8), .DATA_W(6)) wr_if4 ();

  instr_loader #(.ADDR_W(8), .DATA_W(6), .DEPTH(256)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (load_en),
    .strobe    (strobe),
    .data_in   (data_in),
    .wr        (wr_if.master),
    .cpu_rst_n (cpu_rst_n),
    .done      (done),
    .overflow  (overflow),
    .length    (length)
  );

  instr_loader #(.ADDR_W(8), .DATA_W(6), .DEPTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_en   (load_en),
    .strobe    (strobe),
    .data_in   (data_in),
    .wr        (wr_if4.master),
    .cpu_rst_n (cpu_rst_n4),
    .done      (done4),
    .overflow  (overflow4),
    .length    (length4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write/done observers, sampled on the falling edge.
  logic [7:0] qa[$];
  logic [5:0] qd[$];
  int         qc[$];
  logic [7:0] qa4[$];
  logic [5:0] qd4[$];
  int         done_cnt;
  int         done_cyc;
  logic       cpu_low_seen;
  logic       prev_wr_en;
  int         b2b_cnt;

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_if.wr_en) begin
        qa.push_back(wr_if.wr_addr);
        qd.push_back(wr_if.wr_data);
        qc.push_back(cyc);
      end
      if (wr_if4.wr_en) begin
        qa4.push_back(wr_if4.wr_addr);
        qd4.push_back(wr_if4.wr_data);
      end
      if (done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
      if (!cpu_rst_n) cpu_low_seen = 1'b1;
      if (prev_wr_en && wr_if.wr_en) b2b_cnt = b2b_cnt + 1;
      prev_wr_en = wr_if.wr_en;
    end else begin
      prev_wr_en = 1'b0;
    end
  end

  task automatic clear_obs();
    qa.delete(); qd.delete(); qc.delete();
    qa4.delete(); qd4.delete();
    done_cnt = 0;
    done_cyc = -1;
    cpu_low_seen = 1'b0;
  endtask

  task automatic start_load();
    @(negedge clk) load_en = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic end_load();
    @(negedge clk) load_en = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic do_strobe(input logic [5:0] d);
    @(negedge clk);
    data_in = d;
    strobe  = 1'b1;
    repeat (3) @(negedge clk);
    strobe  = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load_en = 1'b0; strobe = 1'b0; data_in = 6'h0;
    repeat (3) @(negedge clk);
    tests++;
    if ({wr_if.wr_en, wr_if.wr_addr, wr_if.wr_data, cpu_rst_n, done, overflow, length} !== 27'd0) begin
      fails++;
      $display("FAIL reset_vals: got en=%b a=%h d=%h cpu=%b done=%b ovf=%b len=%0d, want all 0",
               wr_if.wr_en, wr_if.wr_addr, wr_if.wr_data, cpu_rst_n, done, overflow, length);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (cpu_rst_n !== 1'b1) begin
      fails++;
      $display("FAIL reset_cpu_release: got %b want 1", cpu_rst_n);
    end
  endtask

  task automatic test_basic_load();
    logic [5:0] exp_d [3];
    exp_d[0] = 6'h12; exp_d[1] = 6'h28; exp_d[2] = 6'h3B;
    clear_obs();
    start_load();
    tests++;
    if (cpu_rst_n !== 1'b0) begin
      fails++;
      $display("FAIL basic_cpu_held: got %b want 0", cpu_rst_n);
    end
    for (int i = 0; i < 3; i++) do_strobe(exp_d[i]);
    tests++;
    if (cpu_rst_n !== 1'b0) begin
      fails++;
      $display("FAIL basic_cpu_held_after_writes: got %b want 0", cpu_rst_n);
    end
    end_load();
    tests++;
    if (qa.size() !== 3) begin
      fails++;
      $display("FAIL basic_write_count: got %0d want 3", qa.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (qa[i] !== 8'(i) || qd[i] !== exp_d[i]) begin
          fails++;
          $display("FAIL basic_write%0d: got a=%h d=%h want a=%h d=%h", i, qa[i], qd[i], 8'(i), exp_d[i]);
        end
      end
    end
    tests++;
    if (length !== 9'd3 || done_cnt !== 1 || overflow !== 1'b0 || cpu_rst_n !== 1'b1) begin
      fails++;
      $display("FAIL basic_end: got len=%0d done=%0d ovf=%b cpu=%b want 3 1 0 1",
               length, done_cnt, overflow, cpu_rst_n);
    end
  endtask

  task automatic test_latency();
    logic [4:0] exp_en;
    exp_en = 5'b00100;
    start_load();
    clear_obs();
    @(negedge clk);
    data_in = 6'h15;
    strobe  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (wr_if.wr_en !== exp_en[i]) begin
        fails++;
        $display("FAIL latency_edge_k+%0d: got wr_en=%b want %b", i, wr_if.wr_en, exp_en[i]);
      end
    end
    repeat (5) @(negedge clk);
    strobe = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (qa.size() !== 1 || qd[0] !== 6'h15 || qa[0] !== 8'h00) begin
      fails++;
      $display("FAIL latency_single_write: got n=%0d want 1 write a=00 d=15", qa.size());
    end
    end_load();
    tests++;
    if (length !== 9'd1) begin
      fails++;
      $display("FAIL latency_length: got %0d want 1", length);
    end
  endtask

  task automatic test_idle_strobes();
    clear_obs();
    do_strobe(6'h01);
    do_strobe(6'h02);
    do_strobe(6'h03);
    tests++;
    if (qa.size() !== 0 || cpu_low_seen !== 1'b0 || length !== 9'd1 || done_cnt !== 0) begin
      fails++;
      $display("FAIL idle_strobes: got writes=%0d cpu_low=%b len=%0d done=%0d want 0 0 1 0",
               qa.size(), cpu_low_seen, length, done_cnt);
    end
  endtask

  task automatic test_overflow();
    clear_obs();
    start_load();
    for (int i = 0; i < 6; i++) do_strobe(6'(i + 10));
    end_load();
    tests++;
    if (qa4.size() !== 4) begin
      fails++;
      $display("FAIL ovf_write_count: got %0d want 4", qa4.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (qa4[i] !== 8'(i) || qd4[i] !== 6'(i + 10)) begin
          fails++;
          $display("FAIL ovf_write%0d: got a=%h d=%h want a=%h d=%h", i, qa4[i], qd4[i], 8'(i), 6'(i + 10));
        end
      end
    end
    tests++;
    if (overflow4 !== 1'b1 || length4 !== 9'd4) begin
      fails++;
      $display("FAIL ovf_flags: got ovf=%b len=%0d want 1 4", overflow4, length4);
    end
    tests++;
    if (overflow !== 1'b0 || length !== 9'd6) begin
      fails++;
      $display("FAIL ovf_deep_dut: got ovf=%b len=%0d want 0 6", overflow, length);
    end
    start_load();
    tests++;
    if (overflow4 !== 1'b0) begin
      fails++;
      $display("FAIL ovf_clear_on_rise: got %b want 0", overflow4);
    end
    do_strobe(6'h3F);
    end_load();
    tests++;
    if (length4 !== 9'd1 || overflow4 !== 1'b0) begin
      fails++;
      $display("FAIL ovf_next_session: got len=%0d ovf=%b want 1 0", length4, overflow4);
    end
  endtask

  task automatic test_simultaneous_end();
    clear_obs();
    start_load();
    do_strobe(6'h2A);
    @(negedge clk);
    data_in = 6'h31;
    strobe  = 1'b1;
    load_en = 1'b0;
    repeat (3) @(negedge clk);
    strobe = 1'b0;
    repeat (6) @(negedge clk);
    tests++;
    if (qa.size() !== 2) begin
      fails++;
      $display("FAIL simul_write_count: got %0d want 2", qa.size());
    end else begin
      tests++;
      if (qa[1] !== 8'h01 || qd[1] !== 6'h31) begin
        fails++;
        $display("FAIL simul_last_write: got a=%h d=%h want 01 31", qa[1], qd[1]);
      end
      tests++;
      if (done_cyc !== qc[1]) begin
        fails++;
        $display("FAIL simul_done_timing: got done cycle %0d want %0d", done_cyc, qc[1]);
      end
    end
    tests++;
    if (length !== 9'd2 || done_cnt !== 1) begin
      fails++;
      $display("FAIL simul_length: got len=%0d done=%0d want 2 1", length, done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    start_load();
    do_strobe(6'h05);
    do_strobe(6'h06);
    tests++;
    if (qa.size() !== 2) begin
      fails++;
      $display("FAIL rstmid_pre_writes: got %0d want 2", qa.size());
    end
    @(negedge clk);
    rst_n   = 1'b0;
    load_en = 1'b0;
    #1;
    tests++;
    if ({wr_if.wr_en, wr_if.wr_addr, wr_if.wr_data, cpu_rst_n, done, overflow, length} !== 27'd0) begin
      fails++;
      $display("FAIL rstmid_vals: got en=%b a=%h d=%h cpu=%b done=%b ovf=%b len=%0d, want all 0",
               wr_if.wr_en, wr_if.wr_addr, wr_if.wr_data, cpu_rst_n, done, overflow, length);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_obs();
    start_load();
    do_strobe(6'h07);
    end_load();
    tests++;
    if (qa.size() !== 1 || qa[0] !== 8'h00 || qd[0] !== 6'h07 || length !== 9'd1) begin
      fails++;
      $display("FAIL rstmid_restart: got n=%0d len=%0d want 1 write at 00 d=07 len=1", qa.size(), length);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tests = 0; fails = 0; cyc = 0; b2b_cnt = 0;
    prev_wr_en = 1'b0;
    clear_obs();
    test_reset();
    test_basic_load();
    test_latency();
    test_idle_strobes();
    test_overflow();
    test_simultaneous_end();
    test_reset_mid();
    tests++;
    if (b2b_cnt !== 0) begin
      fails++;
      $display("FAIL back_to_back_wr_en: got %0d consecutive pulses want 0", b2b_cnt);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Writer side of the CPU instruction store. It accepts 6-bit instruction words from off-chip pins through a slow strobe handshake and writes them sequentially into the writable instruction memory, starting at address 0.
- It holds the CPU in reset while loading and releases it when loading ends.
- It sits between the top-level input pins and the instruction memory write port, beside the CPU fetch path.

Parameters:
- ADDR_W, 8, instruction memory address width.
- DATA_W, 6, instruction word width.
- DEPTH, 256, number of writable words; must be <= 2**ADDR_W.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- load_en  in  1  asynchronous level from pin; high = loading session active.
- strobe  in  1  asynchronous from pin; a rising edge presents one word.
- data_in  in  DATA_W  instruction word; host holds it stable from strobe rise until strobe fall.
- wr_en  out  1  one-cycle write pulse to instruction memory.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  DATA_W  write data.
- cpu_rst_n  out  1  active-low reset to the CPU core.
- done  out  1  one-cycle pulse at end of a session.
- overflow  out  1  sticky flag: more than DEPTH words were offered in this session.
- length  out  ADDR_W+1  number of words written in the last completed session.

Behaviour:
- All outputs are registered.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, cpu_rst_n=0, done=0, overflow=0, length=0. State=IDLE, synchronizers=0.
- Synchronization:
  - load_en and strobe each pass through 2 flops, then a history flop.
  - strobe_edge = sync2 & ~hist.
  - load_rise and load_fall are derived the same way.
  - data_in is sampled in the cycle strobe_edge is high (no separate synchronizer; covered by the hold rule).
- Latency: a strobe rise sampled at clk edge k gives wr_en high for exactly the cycle after edge k+2. wr_addr and wr_data are valid in the same cycle as wr_en.
- Internal counter cnt is ADDR_W+1 bits wide.
- IDLE:
  - cpu_rst_n=1 from the first clock after reset.
  - strobe edges are ignored.
  - on load_rise: cnt=0, overflow=0, cpu_rst_n=0, go to LOAD.
- LOAD:
  - on strobe_edge with cnt<DEPTH: wr_en=1, wr_addr=cnt[ADDR_W-1:0], wr_data=data_in, cnt++.
  - on strobe_edge with cnt==DEPTH: no write, overflow=1 (sticky until the next load_rise).
  - on load_fall: go to FINISH.
  - strobe_edge and load_fall in the same cycle: the write is performed, then go to FINISH.
- FINISH (1 cycle): done=1, length=cnt, cpu_rst_n=1 at the end of the cycle, return to IDLE.
- wr_en never asserts outside LOAD and is never high on two consecutive cycles.
- Empty session (load rise then fall, no strobes): length=0, done pulses, no writes.
- Reset mid-LOAD: everything returns to reset values and the CPU stays in reset until the next clock. Words already written remain in memory.
- load_rise while in FINISH is not possible (load_fall precedes it by at least 1 cycle). A load_rise arriving on the IDLE cycle right after FINISH starts a new session normally.

Test Plan:
- Reset, then load_en=1, strobes with data 0x12, 0x28, 0x3B, then load_en=0 -> writes addr 0/1/2 with 0x12/0x28/0x3B. length=3, done pulses once, cpu_rst_n low from LOAD entry until FINISH, overflow=0.
- Strobe rise at clk edge k -> wr_en high only in the cycle after edge k+2. Strobe held high for 10 cycles -> exactly one write.
- Strobes while load_en=0 -> no wr_en, cpu_rst_n stays 1, length unchanged.
- DEPTH=4, 6 strobes in one session -> 4 writes (addr 0-3), overflow=1, length=4. Next session -> overflow cleared on load_rise.
- Last strobe edge and load_en fall synchronized into the same cycle -> word written, length includes it, done the following cycle.
- rst_n asserted mid-session after 2 writes -> all outputs at reset values immediately. A new session then restarts at addr 0.
